// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with a per-register pending scoreboard and pending counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and validity to the read ports.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic              ReadValid1,
  output logic              ReadValid2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReserveRegister,
  input  logic              Reserve,
  output logic [ADDR_W:0]   PendingCount
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            pend_q, pend_d;
  logic [ADDR_W:0]             cnt_q, cnt_d;

  logic wr_ok, rs_ok, cnt_inc, cnt_dec;

  always_comb begin
    wr_ok = RegWrite && !((ZERO_REG != 0) && (WriteRegister == '0));
    rs_ok = Reserve  && !((ZERO_REG != 0) && (ReserveRegister == '0));
    // A write that is overridden by a same-register reserve never clears the bit.
    cnt_inc = rs_ok && !pend_q[ReserveRegister];
    cnt_dec = wr_ok && pend_q[WriteRegister] &&
              !(rs_ok && (ReserveRegister == WriteRegister));
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_ok) begin
      mem_d[WriteRegister]  = WriteData;
      pend_d[WriteRegister] = 1'b0;
    end
    if (rs_ok) pend_d[ReserveRegister] = 1'b1;
    cnt_d = cnt_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][WIDTH-1:0]  rd_data;
  logic [1:0]             rd_vld;

  assign rd_addr = {ReadRegister2, ReadRegister1};

  // Protected register 0 is never written or reserved, so its stored state already reads 0/valid.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem_q[rd_addr[p]];
      rd_vld[p]  = ~pend_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (WriteRegister == rd_addr[p])) begin
        rd_data[p] = WriteData;
        rd_vld[p]  = 1'b1;
      end
`endif
    end
  end

  assign ReadData1    = rd_data[0];
  assign ReadData2    = rd_data[1];
  assign ReadValid1   = rd_vld[0];
  assign ReadValid2   = rd_vld[1];
  assign PendingCount = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, zero register, scoreboard counting,
// same-cycle write/reserve interactions, asynchronous reset and the optional bypass.
module tb_regfile_scoreboard;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister, ReserveRegister;
  logic [31:0] ReadData1, ReadData2, WriteData;
  logic        ReadValid1, ReadValid2, RegWrite, Reserve;
  logic [5:0]  PendingCount;

  int n_tot = 0;
  int n_bad = 0;

  regfile_scoreboard dut (
    .Clk(Clk), .Reset(Reset),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ReadValid1(ReadValid1), .ReadValid2(ReadValid2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReserveRegister(ReserveRegister), .Reserve(Reserve),
    .PendingCount(PendingCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    RegWrite = 1'b0;
    Reserve  = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    ReadRegister1 = '0; ReadRegister2 = '0; WriteRegister = '0; ReserveRegister = '0;
    WriteData = '0; RegWrite = 1'b0; Reserve = 1'b0;
    #2;
    chk("rst_cnt", PendingCount, 0);
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = i[4:0]; ReadRegister2 = i[4:0];
      #0.1;
      chk("rst_d1", ReadData1, 0);
      chk("rst_v1", ReadValid1, 1);
      chk("rst_d2", ReadData2, 0);
      chk("rst_v2", ReadValid2, 1);
    end
    @(negedge Clk);
    Reset = 1'b0;

    // write/read
    WriteRegister = 5; WriteData = 32'hDEADBEEF; RegWrite = 1;
    tick();
    ReadRegister1 = 5; ReadRegister2 = 5; #1;
    chk("wr_d1", ReadData1, 32'hDEADBEEF);
    chk("wr_d2", ReadData2, 32'hDEADBEEF);

    // protected r0
    WriteRegister = 0; WriteData = 32'h12345678; RegWrite = 1;
    ReserveRegister = 0; Reserve = 1;
    tick();
    ReadRegister1 = 0; #1;
    chk("r0_d", ReadData1, 0);
    chk("r0_v", ReadValid1, 1);
    chk("r0_cnt", PendingCount, 0);

    // reserve / re-reserve / write
    ReserveRegister = 7; Reserve = 1;
    tick();
    ReadRegister1 = 7; #1;
    chk("rs7_v", ReadValid1, 0);
    chk("rs7_cnt", PendingCount, 1);
    ReserveRegister = 7; Reserve = 1;
    tick();
    chk("rs7again_cnt", PendingCount, 1);
    WriteRegister = 7; WriteData = 32'hA5A5A5A5; RegWrite = 1;
    tick();
    chk("wr7_v", ReadValid1, 1);
    chk("wr7_d", ReadData1, 32'hA5A5A5A5);
    chk("wr7_cnt", PendingCount, 0);

    // reserve r3 while writing pending r9
    ReserveRegister = 9; Reserve = 1;
    tick();
    chk("rs9_cnt", PendingCount, 1);
    ReserveRegister = 3; Reserve = 1;
    WriteRegister = 9; WriteData = 32'h00000099; RegWrite = 1;
    tick();
    ReadRegister1 = 3; ReadRegister2 = 9; #1;
    chk("mix_cnt", PendingCount, 1);
    chk("mix_v3", ReadValid1, 0);
    chk("mix_v9", ReadValid2, 1);
    chk("mix_d9", ReadData2, 32'h00000099);
    // reserve and write the same non-pending register
    ReserveRegister = 4; Reserve = 1;
    WriteRegister = 4; WriteData = 32'h00000044; RegWrite = 1;
    tick();
    ReadRegister1 = 4; #1;
    chk("same4_d", ReadData1, 32'h00000044);
    chk("same4_v", ReadValid1, 0);
    chk("same4_cnt", PendingCount, 2);

    // fill scoreboard
    for (int i = 1; i < 32; i++) begin
      ReserveRegister = i[4:0]; Reserve = 1;
      tick();
    end
    chk("full_cnt", PendingCount, 31);
    ReadRegister1 = 31; #1;
    chk("full_v31", ReadValid1, 0);

    // asynchronous reset between edges
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_cnt", PendingCount, 0);
    ReadRegister1 = 7; ReadRegister2 = 31; #1;
    chk("arst_v7", ReadValid1, 1);
    chk("arst_v31", ReadValid2, 1);
    ReadRegister1 = 5; #1;
    chk("arst_d5", ReadData1, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // forwarding behaviour
    WriteRegister = 6; WriteData = 32'h11111111; RegWrite = 1;
    tick();
    ReserveRegister = 6; Reserve = 1;
    tick();
    WriteRegister = 6; WriteData = 32'h0BADF00D; RegWrite = 1;
    ReadRegister1 = 6; #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_d", ReadData1, 32'h0BADF00D);
    chk("byp_v", ReadValid1, 1);
`else
    chk("nobyp_d", ReadData1, 32'h11111111);
    chk("nobyp_v", ReadValid1, 0);
`endif
    tick();
    chk("wb6_d", ReadData1, 32'h0BADF00D);
    chk("wb6_v", ReadValid1, 1);
    chk("wb6_cnt", PendingCount, 0);
    WriteRegister = 0; WriteData = 32'hFFFFFFFF; RegWrite = 1;
    ReadRegister2 = 0; #1;
    chk("byp_r0_d", ReadData2, 0);
    chk("byp_r0_v", ReadValid2, 1);
    tick();
    chk("r0_after_d", ReadData2, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised MIPS-style register file: configurable width, depth and hard-zero register 0. Two asynchronous read ports and one synchronous write port. Adds a per-register pending scoreboard so the pipeline can reserve a destination at issue and stall readers until writeback. Sits between decode (reads/reserve) and writeback (write) in the CPU datapath.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 32, number of registers; power of two, 2..256
ADDR_W, 5, address width; must equal log2(DEPTH)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and reserves; 0 = register 0 is ordinary

Ports:
Clk  in  1  clock, positive-edge triggered
Reset  in  1  asynchronous, active-high reset
ReadRegister1  in  ADDR_W  address for read port 1
ReadRegister2  in  ADDR_W  address for read port 2
ReadData1  out  WIDTH  contents for read port 1
ReadData2  out  WIDTH  contents for read port 2
ReadValid1  out  1  1 = ReadData1 is not awaiting a pending write
ReadValid2  out  1  1 = ReadData2 is not awaiting a pending write
WriteRegister  in  ADDR_W  write address
WriteData  in  WIDTH  write data
RegWrite  in  1  write enable
ReserveRegister  in  ADDR_W  register to mark pending
Reserve  in  1  reserve enable
PendingCount  out  ADDR_W+1  number of registers currently pending

Behaviour:
- One clock, Clk. Reset is asynchronous and active-high. While Reset is high: all registers = 0, all pending bits = 0, PendingCount = 0. Reset asserted mid-operation discards every in-flight reservation immediately, not at the next edge.
- Protected register: register 0 when ZERO_REG=1. Writes and reserves to it are no-ops. Its reads return 0 with ReadValidN = 1.
- Write: at posedge Clk, RegWrite=1 and WriteRegister not protected -> mem[WriteRegister] <= WriteData; pending[WriteRegister] <= 0.
- Reserve: at posedge Clk, Reserve=1 and ReserveRegister not protected -> pending[ReserveRegister] <= 1.
- Write and reserve to the same register in the same cycle: data updates and pending ends at 1 (the new producer wins).
- Reserve of an already-pending register: no change; the count does not increment.
- Write to a non-pending register: data updates; the count does not decrement.
- PendingCount is a registered counter updated at each posedge.
  - Increment per reserve that sets a 0 bit.
  - Decrement per write that clears a 1 bit.
  - Net 0 when both occur on different registers.
  - Must always equal the popcount of the pending bits. Range 0..DEPTH with no wrap; width ADDR_W+1 holds DEPTH.
- Reads are combinational, 0-cycle latency: ReadDataN = mem[ReadRegisterN]; ReadValidN = ~pending[ReadRegisterN]. Both ports may address the same register.
- Without bypass, a register written at edge k is visible on reads after edge k.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - Applies when RegWrite=1, WriteRegister==ReadRegisterN and the register is not protected.
  - ReadDataN = WriteData and ReadValidN = 1 in the same cycle, before the edge. This holds even if Reserve targets the same register that cycle.
  - A protected register still reads 0.
- Undefined: no forwarding. Reads return the stored value and the stored pending bit until the edge commits.
- Storage, scoreboard and counter behaviour are identical in both builds.

Test Plan:
1. Reset -> every ReadRegister 0..31 gives ReadData 0, ReadValid 1, PendingCount 0. Write 0xDEADBEEF to r5, read r5 on both ports -> 0xDEADBEEF after the edge.
2. ZERO_REG=1: write 0x12345678 to r0, Reserve r0 -> r0 reads 0, ReadValid 1, PendingCount 0.
3. Reserve r7 -> ReadValid1=0 for r7 and PendingCount=1. Reserve r7 again -> count stays 1. Write 0xA5A5A5A5 to r7 -> ReadValid1=1, data 0xA5A5A5A5, count 0.
4. Same cycle: Reserve r3 while writing r9 (pending) -> count unchanged at 1, r3 pending, r9 valid. Same cycle: reserve and write r4 (4 not pending) -> r4 holds the new data, pending=1, count +1.
5. Reserve r1..r31 -> PendingCount=31. Assert Reset asynchronously mid-cycle -> count 0 and all ReadValid=1 before the next Clk edge.
6. REGFILE_BYPASS_EN defined: r6 pending, RegWrite r6=0x0BADF00D, read r6 same cycle -> ReadData1=0x0BADF00D, ReadValid1=1. Undefined: old value and ReadValid1=0 until the edge.
